// File: rtl/handshake_4phase_rsp_if.sv
// -----------------------------------------------------------------------------
// handshake_4phase_rsp_if
//
// Purpose:
//   Bundles every signal of the 4-phase responder that is not clock or reset.
//   It covers the asynchronous req/ack side that faces the remote initiator and
//   the two local valid/ready streams. The payload types are parameters so the
//   same interface can carry anything from a single bit to a packed struct.
//
// Modports:
//   slave  - the responder block itself (handshake_4phase_rsp).
//   master - the environment around it: the remote initiator plus local logic.
//
// Signals (direction as seen by the responder):
//   async_req_i       in   initiator request level, asynchronous
//   async_req_data_i  in   request payload, stable while async_req_i is high
//   async_ack_o       out  registered acknowledge level
//   async_rsp_data_o  out  registered response payload, valid while ack high
//   req_valid_o       out  captured request available to local logic
//   req_ready_i       in   local logic accepts the request
//   req_data_o        out  captured request payload
//   rsp_valid_i       in   local response available
//   rsp_ready_o       out  responder accepts the response
//   rsp_data_i        in   local response payload
//   busy_o            out  a transaction is in progress
//   err_o             out  sticky protocol error flag
// -----------------------------------------------------------------------------
interface handshake_4phase_rsp_if #(
    parameter type REQ_T = logic,
    parameter type RSP_T = logic
);

    logic async_req_i;
    REQ_T async_req_data_i;
    logic async_ack_o;
    RSP_T async_rsp_data_o;

    logic req_valid_o;
    logic req_ready_i;
    REQ_T req_data_o;

    logic rsp_valid_i;
    logic rsp_ready_o;
    RSP_T rsp_data_i;

    logic busy_o;
    logic err_o;

    // Responder view: consumes the request/response inputs and drives the rest.
    modport slave (
        input  async_req_i,
        input  async_req_data_i,
        output async_ack_o,
        output async_rsp_data_o,
        output req_valid_o,
        input  req_ready_i,
        output req_data_o,
        input  rsp_valid_i,
        output rsp_ready_o,
        input  rsp_data_i,
        output busy_o,
        output err_o
    );

    // Environment view: the initiator and local logic driving the responder.
    modport master (
        output async_req_i,
        output async_req_data_i,
        input  async_ack_o,
        input  async_rsp_data_o,
        input  req_valid_o,
        output req_ready_i,
        input  req_data_o,
        output rsp_valid_i,
        input  rsp_ready_o,
        output rsp_data_i,
        input  busy_o,
        input  err_o
    );

endinterface

// File: rtl/handshake_4phase_rsp.sv
// -----------------------------------------------------------------------------
// handshake_4phase_rsp
//
// Purpose:
//   Single-clock responder for a 4-phase req/ack link. The initiator runs on an
//   unrelated clock, or on no clock at all. The responder synchronizes the
//   incoming request level and captures the request payload once the
//   synchronized request is seen. It offers that payload to local logic as a
//   valid/ready stream. It then takes the local answer over a second
//   valid/ready stream and returns it to the initiator together with the
//   acknowledge. The acknowledge is held until the initiator drops its
//   request. This completes the four phases.
//
// Parameters:
//   REQ_T        type of the request payload
//   RSP_T        type of the response payload
//   SYNC_STAGES  synchronizer depth on async_req_i (must be at least 2)
//
// Ports:
//   clk_i   clock, all state changes on the rising edge
//   rst_ni  synchronous active-low reset
//   bus     handshake_4phase_rsp_if.slave carrying the async req/ack pair,
//           both payloads, the two local streams, busy_o and err_o
// -----------------------------------------------------------------------------
module handshake_4phase_rsp #(
    parameter type REQ_T       = logic,
    parameter type RSP_T       = logic,
    parameter int  SYNC_STAGES = 2
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    handshake_4phase_rsp_if.slave bus
);

    // The four phases of one transaction as seen from the responder side.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        REQ_OUT      = 2'd1,
        WAIT_RSP     = 2'd2,
        WAIT_REQ_LOW = 2'd3
    } HsState;

    HsState                 r_state;
    HsState                 w_nextState;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_reqSynced;

    REQ_T                   r_reqData;
    RSP_T                   r_rspData;
    logic                   r_ack;
    logic                   r_err;

    logic                   w_captureReq;
    logic                   w_captureRsp;
    logic                   w_ackNext;
    logic                   w_errSet;

    // The request level is the only control signal that crosses clock domains.
    // It passes through a plain flop chain. The last stage is the only
    // version of the request that the rest of the block ever looks at.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.async_req_i};
        end
    end

    assign w_reqSynced = r_sync[SYNC_STAGES-1];

    // State register. Reset always brings the block back to IDLE. If the
    // initiator still holds its request at that point, the same request is
    // picked up again once reset is released.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and event decode. The request payload is sampled only once the
    // synchronized request is high. The initiator keeps it stable for as long
    // as the request is up, so it is settled by then. A request that drops
    // before the transaction is answered is flagged as an error. The
    // transaction still runs to completion, so the local side never sees a
    // half-finished exchange. The acknowledge is raised together with the
    // response capture and cleared only when the request has been seen low.
    always_comb begin
        w_nextState  = r_state;
        w_captureReq = 1'b0;
        w_captureRsp = 1'b0;
        w_ackNext    = r_ack;
        w_errSet     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_reqSynced) begin
                    w_captureReq = 1'b1;
                    w_nextState  = REQ_OUT;
                end
            end

            REQ_OUT: begin
                if (!w_reqSynced) begin
                    w_errSet = 1'b1;
                end
                if (bus.req_ready_i) begin
                    w_nextState = WAIT_RSP;
                end
            end

            WAIT_RSP: begin
                if (!w_reqSynced) begin
                    w_errSet = 1'b1;
                end
                if (bus.rsp_valid_i) begin
                    w_captureRsp = 1'b1;
                    w_ackNext    = 1'b1;
                    w_nextState  = WAIT_REQ_LOW;
                end
            end

            WAIT_REQ_LOW: begin
                w_ackNext = 1'b1;
                if (!w_reqSynced) begin
                    w_ackNext   = 1'b0;
                    w_nextState = IDLE;
                end
            end

            default: begin
                w_ackNext   = 1'b0;
                w_nextState = IDLE;
            end
        endcase
    end

    // Acknowledge flop. The ack goes straight to the initiator's clock domain,
    // so it must come from a register and must never glitch.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= w_ackNext;
        end
    end

    // Payload holding registers. Each one changes only on its own capture
    // event. The request payload stays visible until the next request is
    // captured. The response payload stays visible after the ack falls, until
    // the next response is captured.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_reqData <= '0;
            r_rspData <= '0;
        end else begin
            if (w_captureReq) begin
                r_reqData <= bus.async_req_data_i;
            end
            if (w_captureRsp) begin
                r_rspData <= bus.rsp_data_i;
            end
        end
    end

    // Sticky protocol error. Once set, only reset clears it. This lets
    // software or a debugger inspect it long after the bad transaction.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_errSet) begin
            r_err <= 1'b1;
        end
    end

    // The local stream controls are decoded from the registered state alone.
    // As a result, neither valid nor ready has a combinational path from the
    // other side's handshake input.
    assign bus.req_valid_o      = (r_state == REQ_OUT);
    assign bus.rsp_ready_o      = (r_state == WAIT_RSP);
    assign bus.busy_o           = (r_state != IDLE);
    assign bus.req_data_o       = r_reqData;
    assign bus.async_ack_o      = r_ack;
    assign bus.async_rsp_data_o = r_rspData;
    assign bus.err_o            = r_err;

endmodule

// File: tb/tb_handshake_4phase_rsp.sv
// -----------------------------------------------------------------------------
// tb_handshake_4phase_rsp
//
// Purpose:
//   Self-checking bench for handshake_4phase_rsp with 8-bit payloads and a
//   two-stage synchronizer. Directed scenarios cover reset, latency, back
//   pressure, ignored early responses, the protocol error flag and reset in
//   the middle of a transaction. A randomized run follows. In it, an initiator
//   on its own randomly chosen period exchanges 100 transactions with a local
//   responder that uses random delays. A scoreboard checks that every request
//   and response arrives exactly once and in order.
// -----------------------------------------------------------------------------
module tb_handshake_4phase_rsp;

    typedef logic [7:0] byte_t;

    localparam int SYNC    = 2;
    localparam int NUM_TXN = 100;

    logic  clk;
    logic  rstN;
    int    checks;
    int    failures;
    byte_t lastRsp;

    handshake_4phase_rsp_if #(.REQ_T(byte_t), .RSP_T(byte_t)) bus ();

    handshake_4phase_rsp #(
        .REQ_T      (byte_t),
        .RSP_T      (byte_t),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk_i (clk),
        .rst_ni(rstN),
        .bus   (bus.slave)
    );

    // Local clock with a 20 ns period. Rising edges fall at 10 mod 20 and
    // falling edges at 0 mod 20.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Hard stop in case something waits forever despite the bounded loops.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one full clock and land on the following falling edge. That is
    // where all sampling and driving happens.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic req, input byte_t reqData, input logic reqReady,
                                 input logic rspValid, input byte_t rspData);
        bus.async_req_i      = req;
        bus.async_req_data_i = reqData;
        bus.req_ready_i      = reqReady;
        bus.rsp_valid_i      = rspValid;
        bus.rsp_data_i       = rspData;
    endtask

    // Reset state: every output is low or zero.
    task automatic test_reset();
        rstN = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle();
        cycle();
        checks++; if (bus.async_ack_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack: got %b, expected 0", bus.async_ack_o); end
        checks++; if (bus.req_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_valid: got %b, expected 0", bus.req_valid_o); end
        checks++; if (bus.rsp_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_ready: got %b, expected 0", bus.rsp_ready_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy_o); end
        checks++; if (bus.err_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b, expected 0", bus.err_o); end
        checks++; if (bus.req_data_o !== 8'h00) begin failures++; $display("[TB] FAIL reset_req_data: got %h, expected 00", bus.req_data_o); end
        checks++; if (bus.async_rsp_data_o !== 8'h00) begin failures++; $display("[TB] FAIL reset_rsp_data: got %h, expected 00", bus.async_rsp_data_o); end
        rstN = 1'b1;
        cycle();
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_release_busy: got %b, expected 0", bus.busy_o); end
        lastRsp = 8'h00;
    endtask

    // One transaction with the local side always ready. The request is driven
    // just after a falling edge, so the next rising edge is the first to sample
    // it. The captured payload appears after that edge plus SYNC more edges.
    // The ack needs two further edges. The release takes the sampling edge
    // plus SYNC more edges.
    task automatic test_single();
        int n;
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b1, 8'h3C);
        n = 0;
        do begin cycle(); n++; end while (bus.req_valid_o !== 1'b1 && n < 20);
        checks++; if (n !== SYNC + 1) begin failures++; $display("[TB] FAIL single_req_latency: got %0d cycles, expected %0d", n, SYNC + 1); end
        checks++; if (bus.req_data_o !== 8'hA5) begin failures++; $display("[TB] FAIL single_req_data: got %h, expected a5", bus.req_data_o); end
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("[TB] FAIL single_busy: got %b, expected 1", bus.busy_o); end
        n = 0;
        do begin cycle(); n++; end while (bus.async_ack_o !== 1'b1 && n < 20);
        checks++; if (n !== 2) begin failures++; $display("[TB] FAIL single_ack_latency: got %0d cycles, expected 2", n); end
        checks++; if (bus.async_rsp_data_o !== 8'h3C) begin failures++; $display("[TB] FAIL single_rsp_data: got %h, expected 3c", bus.async_rsp_data_o); end
        bus.async_req_i = 1'b0;
        n = 0;
        do begin cycle(); n++; end while (bus.async_ack_o !== 1'b0 && n < 20);
        checks++; if (n !== SYNC + 1) begin failures++; $display("[TB] FAIL single_ack_release: got %0d cycles, expected %0d", n, SYNC + 1); end
        checks++; if (bus.async_rsp_data_o !== 8'h3C) begin failures++; $display("[TB] FAIL single_rsp_hold: got %h, expected 3c", bus.async_rsp_data_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL single_idle_busy: got %b, expected 0", bus.busy_o); end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        lastRsp = 8'h3C;
    endtask

    // Local side stalls the request for five cycles and then the response for
    // four cycles.
    task automatic test_backpressure();
        int n;
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0, 8'h00);
        n = 0;
        do begin cycle(); n++; end while (bus.req_valid_o !== 1'b1 && n < 20);
        checks++; if (n !== SYNC + 1) begin failures++; $display("[TB] FAIL bp_req_latency: got %0d cycles, expected %0d", n, SYNC + 1); end
        for (int i = 0; i < 5; i++) begin
            checks++; if ({bus.req_valid_o, bus.req_data_o} !== {1'b1, 8'hC3}) begin failures++; $display("[TB] FAIL bp_req_hold cycle %0d: got valid=%b data=%h, expected valid=1 data=c3", i, bus.req_valid_o, bus.req_data_o); end
            checks++; if (bus.rsp_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_rsp_ready_early cycle %0d: got %b, expected 0", i, bus.rsp_ready_o); end
            cycle();
        end
        bus.req_ready_i = 1'b1;
        checks++; if (bus.req_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL bp_req_valid_at_accept: got %b, expected 1", bus.req_valid_o); end
        cycle();
        bus.req_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({bus.rsp_ready_o, bus.async_ack_o, bus.req_valid_o} !== 3'b100) begin failures++; $display("[TB] FAIL bp_wait_rsp cycle %0d: got ready/ack/valid=%b, expected 100", i, {bus.rsp_ready_o, bus.async_ack_o, bus.req_valid_o}); end
            cycle();
        end
        bus.rsp_valid_i = 1'b1;
        bus.rsp_data_i  = 8'h5A;
        checks++; if (bus.rsp_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL bp_rsp_ready_final: got %b, expected 1", bus.rsp_ready_o); end
        cycle();
        bus.rsp_valid_i = 1'b0;
        checks++; if ({bus.async_ack_o, bus.rsp_ready_o} !== 2'b10) begin failures++; $display("[TB] FAIL bp_ack_after_rsp: got ack/ready=%b, expected 10", {bus.async_ack_o, bus.rsp_ready_o}); end
        checks++; if (bus.async_rsp_data_o !== 8'h5A) begin failures++; $display("[TB] FAIL bp_rsp_data: got %h, expected 5a", bus.async_rsp_data_o); end
        bus.async_req_i = 1'b0;
        n = 0;
        do begin cycle(); n++; end while (bus.async_ack_o !== 1'b0 && n < 20);
        checks++; if ({bus.async_ack_o, bus.busy_o} !== 2'b00) begin failures++; $display("[TB] FAIL bp_release: got ack/busy=%b, expected 00", {bus.async_ack_o, bus.busy_o}); end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        lastRsp = 8'h5A;
    endtask

    // Response offered before it is wanted is ignored. Only the value present
    // while the block waits for a response is captured.
    task automatic test_early_rsp();
        int n;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h77);
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++; if ({bus.rsp_ready_o, bus.async_ack_o} !== 2'b00) begin failures++; $display("[TB] FAIL early_idle cycle %0d: got ready/ack=%b, expected 00", i, {bus.rsp_ready_o, bus.async_ack_o}); end
            checks++; if (bus.async_rsp_data_o !== lastRsp) begin failures++; $display("[TB] FAIL early_idle_data cycle %0d: got %h, expected %h", i, bus.async_rsp_data_o, lastRsp); end
        end
        bus.async_req_data_i = 8'h96;
        bus.async_req_i      = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
            checks++; if (bus.rsp_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL early_sync_ready cycle %0d: got %b, expected 0", n, bus.rsp_ready_o); end
        end while (bus.req_valid_o !== 1'b1 && n < 20);
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++; if ({bus.req_valid_o, bus.rsp_ready_o, bus.async_ack_o} !== 3'b100) begin failures++; $display("[TB] FAIL early_req_out cycle %0d: got valid/ready/ack=%b, expected 100", i, {bus.req_valid_o, bus.rsp_ready_o, bus.async_ack_o}); end
            checks++; if (bus.async_rsp_data_o !== lastRsp) begin failures++; $display("[TB] FAIL early_req_out_data cycle %0d: got %h, expected %h", i, bus.async_rsp_data_o, lastRsp); end
        end
        bus.req_ready_i = 1'b1;
        cycle();
        bus.req_ready_i = 1'b0;
        checks++; if ({bus.rsp_ready_o, bus.async_ack_o} !== 2'b10) begin failures++; $display("[TB] FAIL early_enter_wait: got ready/ack=%b, expected 10", {bus.rsp_ready_o, bus.async_ack_o}); end
        checks++; if (bus.async_rsp_data_o !== lastRsp) begin failures++; $display("[TB] FAIL early_no_capture: got %h, expected %h", bus.async_rsp_data_o, lastRsp); end
        bus.rsp_data_i = 8'h11;
        cycle();
        bus.rsp_valid_i = 1'b0;
        checks++; if ({bus.async_ack_o, bus.async_rsp_data_o} !== {1'b1, 8'h11}) begin failures++; $display("[TB] FAIL early_capture: got ack=%b data=%h, expected ack=1 data=11", bus.async_ack_o, bus.async_rsp_data_o); end
        bus.async_req_i = 1'b0;
        n = 0;
        do begin cycle(); n++; end while (bus.async_ack_o !== 1'b0 && n < 20);
        checks++; if (bus.async_ack_o !== 1'b0) begin failures++; $display("[TB] FAIL early_release: got %b, expected 0", bus.async_ack_o); end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        lastRsp = 8'h11;
    endtask

    // Request withdrawn while the response is pending.
    task automatic test_protocol_error();
        int n;
        applyStimulus(1'b1, 8'h3E, 1'b1, 1'b0, 8'h00);
        n = 0;
        do begin cycle(); n++; end while (bus.req_valid_o !== 1'b1 && n < 20);
        cycle();
        checks++; if ({bus.rsp_ready_o, bus.err_o} !== 2'b10) begin failures++; $display("[TB] FAIL perr_before_drop: got ready/err=%b, expected 10", {bus.rsp_ready_o, bus.err_o}); end
        bus.req_ready_i = 1'b0;
        bus.async_req_i = 1'b0;
        repeat (SYNC + 1) cycle();
        checks++; if ({bus.err_o, bus.async_ack_o, bus.busy_o} !== 3'b101) begin failures++; $display("[TB] FAIL perr_flag: got err/ack/busy=%b, expected 101", {bus.err_o, bus.async_ack_o, bus.busy_o}); end
        bus.rsp_valid_i = 1'b1;
        bus.rsp_data_i  = 8'hE7;
        cycle();
        bus.rsp_valid_i = 1'b0;
        checks++; if ({bus.async_ack_o, bus.async_rsp_data_o} !== {1'b1, 8'hE7}) begin failures++; $display("[TB] FAIL perr_completes: got ack=%b data=%h, expected ack=1 data=e7", bus.async_ack_o, bus.async_rsp_data_o); end
        n = 0;
        do begin cycle(); n++; end while (bus.async_ack_o !== 1'b0 && n < 20);
        checks++; if (bus.async_ack_o !== 1'b0) begin failures++; $display("[TB] FAIL perr_ack_release: got %b, expected 0", bus.async_ack_o); end
        repeat (3) cycle();
        checks++; if ({bus.err_o, bus.busy_o} !== 2'b10) begin failures++; $display("[TB] FAIL perr_sticky: got err/busy=%b, expected 10", {bus.err_o, bus.busy_o}); end
        rstN = 1'b0;
        cycle();
        rstN = 1'b1;
        checks++; if (bus.err_o !== 1'b0) begin failures++; $display("[TB] FAIL perr_clear_on_reset: got %b, expected 0", bus.err_o); end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        lastRsp = 8'h00;
    endtask

    // Reset while the ack is held, request still high: the request is
    // delivered a second time after reset.
    task automatic test_reset_mid();
        int n;
        applyStimulus(1'b1, 8'hD2, 1'b1, 1'b1, 8'h4B);
        n = 0;
        do begin cycle(); n++; end while (bus.async_ack_o !== 1'b1 && n < 20);
        bus.req_ready_i = 1'b0;
        bus.rsp_valid_i = 1'b0;
        cycle();
        checks++; if ({bus.async_ack_o, bus.async_rsp_data_o} !== {1'b1, 8'h4B}) begin failures++; $display("[TB] FAIL rmid_ack_held: got ack=%b data=%h, expected ack=1 data=4b", bus.async_ack_o, bus.async_rsp_data_o); end
        rstN = 1'b0;
        cycle();
        checks++; if ({bus.async_ack_o, bus.req_valid_o, bus.busy_o} !== 3'b000) begin failures++; $display("[TB] FAIL rmid_reset: got ack/valid/busy=%b, expected 000", {bus.async_ack_o, bus.req_valid_o, bus.busy_o}); end
        rstN = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (bus.req_valid_o !== 1'b1 && n < 20);
        checks++; if (n !== SYNC + 1) begin failures++; $display("[TB] FAIL rmid_redeliver_latency: got %0d cycles, expected %0d", n, SYNC + 1); end
        checks++; if (bus.req_data_o !== 8'hD2) begin failures++; $display("[TB] FAIL rmid_redeliver_data: got %h, expected d2", bus.req_data_o); end
        bus.req_ready_i = 1'b1;
        bus.rsp_valid_i = 1'b1;
        bus.rsp_data_i  = 8'h4C;
        n = 0;
        do begin cycle(); n++; end while (bus.async_ack_o !== 1'b1 && n < 20);
        bus.req_ready_i = 1'b0;
        bus.rsp_valid_i = 1'b0;
        checks++; if (bus.async_rsp_data_o !== 8'h4C) begin failures++; $display("[TB] FAIL rmid_second_rsp: got %h, expected 4c", bus.async_rsp_data_o); end
        bus.async_req_i = 1'b0;
        n = 0;
        do begin cycle(); n++; end while (bus.async_ack_o !== 1'b0 && n < 20);
        checks++; if ({bus.async_ack_o, bus.busy_o} !== 2'b00) begin failures++; $display("[TB] FAIL rmid_release: got ack/busy=%b, expected 00", {bus.async_ack_o, bus.busy_o}); end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    // Randomized traffic. The reference model is the transaction rule itself:
    // the n-th request sent must be the n-th request delivered locally. The
    // n-th response given locally must be the n-th response the initiator
    // sees with its ack. Initiator times sit at 3 mod 10 ns, so they never
    // coincide with a local clock edge.
    task automatic test_random();
        byte_t reqSent[$];
        byte_t reqRecv[$];
        byte_t rspSent[$];
        byte_t rspRecv[$];
        int    initPeriod;
        bit    abort;
        abort      = 1'b0;
        initPeriod = 10 * int'($urandom_range(1, 7));
        $display("[TB] random run: initiator period %0d ns against local period 20 ns", initPeriod);
        fork
            begin : initiator
                #3;
                for (int t = 0; t < NUM_TXN; t++) begin
                    int    w;
                    byte_t d;
                    if (abort) break;
                    repeat ($urandom_range(0, 4)) #(initPeriod);
                    d = byte_t'($urandom);
                    reqSent.push_back(d);
                    bus.async_req_data_i = d;
                    bus.async_req_i      = 1'b1;
                    w = 0;
                    while (bus.async_ack_o !== 1'b1 && w < 400 && !abort) begin #(initPeriod); w++; end
                    checks++; if (bus.async_ack_o !== 1'b1) begin failures++; $display("[TB] FAIL rand_ack_rise txn %0d: got %b, expected 1", t, bus.async_ack_o); abort = 1'b1; break; end
                    rspRecv.push_back(bus.async_rsp_data_o);
                    bus.async_req_i = 1'b0;
                    w = 0;
                    while (bus.async_ack_o !== 1'b0 && w < 400) begin #(initPeriod); w++; end
                    checks++; if (bus.async_ack_o !== 1'b0) begin failures++; $display("[TB] FAIL rand_ack_fall txn %0d: got %b, expected 0", t, bus.async_ack_o); abort = 1'b1; break; end
                end
            end
            begin : localSide
                for (int t = 0; t < NUM_TXN; t++) begin
                    int    n;
                    byte_t d;
                    if (abort) break;
                    n = 0;
                    while (bus.req_valid_o !== 1'b1 && n < 2000 && !abort) begin @(negedge clk); n++; end
                    if (abort) break;
                    checks++; if (bus.req_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL rand_req_valid txn %0d: got %b, expected 1", t, bus.req_valid_o); abort = 1'b1; break; end
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    reqRecv.push_back(bus.req_data_o);
                    bus.req_ready_i = 1'b1;
                    @(negedge clk);
                    bus.req_ready_i = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    d = byte_t'($urandom);
                    bus.rsp_data_i  = d;
                    bus.rsp_valid_i = 1'b1;
                    rspSent.push_back(d);
                    checks++; if (bus.rsp_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL rand_rsp_ready txn %0d: got %b, expected 1", t, bus.rsp_ready_o); end
                    @(negedge clk);
                    bus.rsp_valid_i = 1'b0;
                end
            end
        join
        checks++; if (reqRecv.size() !== NUM_TXN) begin failures++; $display("[TB] FAIL rand_req_count: got %0d, expected %0d", reqRecv.size(), NUM_TXN); end
        checks++; if (rspRecv.size() !== NUM_TXN) begin failures++; $display("[TB] FAIL rand_rsp_count: got %0d, expected %0d", rspRecv.size(), NUM_TXN); end
        for (int i = 0; i < reqRecv.size() && i < reqSent.size(); i++) begin
            checks++; if (reqRecv[i] !== reqSent[i]) begin failures++; $display("[TB] FAIL rand_req_data txn %0d: got %h, expected %h", i, reqRecv[i], reqSent[i]); end
        end
        for (int i = 0; i < rspRecv.size() && i < rspSent.size(); i++) begin
            checks++; if (rspRecv[i] !== rspSent[i]) begin failures++; $display("[TB] FAIL rand_rsp_data txn %0d: got %h, expected %h", i, rspRecv[i], rspSent[i]); end
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        repeat (SYNC + 2) cycle();
        checks++; if ({bus.busy_o, bus.async_ack_o, bus.err_o} !== 3'b000) begin failures++; $display("[TB] FAIL rand_final_idle: got busy/ack/err=%b, expected 000", {bus.busy_o, bus.async_ack_o, bus.err_o}); end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin : main
        checks   = 0;
        failures = 0;
        lastRsp  = 8'h00;
        test_reset();
        test_single();
        test_backpressure();
        test_early_rsp();
        test_protocol_error();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
